// File: rtl/byte_inc_sched_pkg.sv
// Shared types for the byte_inc job scheduler: FSM state encoding and the job
// descriptor view, sized for the widest supported engine (16-bit addresses, 16 requesters).
package byte_inc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned JOB_ADDR_W = 16;
  localparam int unsigned JOB_ID_W   = 4;

  typedef struct packed {
    logic [JOB_ADDR_W-1:0] base_addr;
    logic [JOB_ADDR_W-1:0] length;
    logic [JOB_ID_W-1:0]   id;
  } job_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting from the requester after the last winner.
// The pointer only moves when the grant is actually taken (advance).
module rr_arbiter #(
  parameter  int unsigned N = 4,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_id
);

  logic [W-1:0] ptr;
  logic         found;
  logic [W-1:0] sel;
  int unsigned  idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    sel      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= N) idx = idx - N;
      sel = idx[W-1:0];
      if (!found && req[sel]) begin
        found      = 1'b1;
        grant[sel] = 1'b1;
        grant_id   = sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= (grant_id == W'(N - 1)) ? '0 : grant_id + W'(1);
    end
  end

endmodule

// File: rtl/byte_inc_sched.sv
// Serialises per-requester job descriptors onto the single byte_inc engine set port,
// retiring zero-length and out-of-range jobs locally with a completion pulse.
module byte_inc_sched
  import byte_inc_sched_pkg::*;
#(
  parameter  int unsigned N_REQ      = 4,
  parameter  int unsigned ADDR_WIDTH = 10,
  localparam int unsigned ID_W       = $clog2(N_REQ)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_REQ-1:0]                    req_valid_i,
  output logic [N_REQ-1:0]                    req_ready_o,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]    req_base_addr_i,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]    req_length_i,
  output logic [ADDR_WIDTH-1:0]               eng_base_addr_o,
  output logic [ADDR_WIDTH-1:0]               eng_length_o,
  output logic                                eng_run_o,
  input  logic                                eng_waitrequest_i,
  output logic                                done_valid_o,
  output logic [ID_W-1:0]                     done_id_o,
  output logic                                done_err_o,
  output logic                                busy_o
);

  state_t                state;
  logic [N_REQ-1:0]      grant;
  logic [ID_W-1:0]       grant_id;
  logic                  can_grant;
  logic                  take;
  logic [ADDR_WIDTH-1:0] sel_base;
  logic [ADDR_WIDTH-1:0] sel_len;
  logic [ADDR_WIDTH:0]   sel_end;
  logic                  sel_over;
  logic [ID_W-1:0]       job_id;
  logic                  first_run;

  // Ready is gated by rst_n so no requester sees a grant while reset is held.
  assign can_grant   = rst_n && (state == IDLE);
  assign take        = can_grant && (|req_valid_i);
  assign req_ready_o = can_grant ? grant : '0;

  assign sel_base = req_base_addr_i[grant_id];
  assign sel_len  = req_length_i[grant_id];
  assign sel_end  = {1'b0, sel_base} + {1'b0, sel_len};
  assign sel_over = sel_end > {1'b1, {ADDR_WIDTH{1'b0}}};

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_valid_i),
    .advance  (take),
    .grant    (grant),
    .grant_id (grant_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      eng_base_addr_o <= '0;
      eng_length_o    <= '0;
      eng_run_o       <= 1'b0;
      done_valid_o    <= 1'b0;
      done_id_o       <= '0;
      done_err_o      <= 1'b0;
      busy_o          <= 1'b0;
      job_id          <= '0;
      first_run       <= 1'b0;
    end else begin
      done_valid_o <= 1'b0;
      done_id_o    <= '0;
      done_err_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            job_id <= grant_id;
            busy_o <= 1'b1;
            if (sel_len == '0) begin
              state        <= DONE;
              done_valid_o <= 1'b1;
              done_id_o    <= grant_id;
            end else if (sel_over) begin
              state        <= DONE;
              done_valid_o <= 1'b1;
              done_id_o    <= grant_id;
              done_err_o   <= 1'b1;
            end else begin
              state           <= ISSUE;
              eng_run_o       <= 1'b1;
              eng_base_addr_o <= sel_base;
              eng_length_o    <= sel_len;
            end
          end
        end
        ISSUE: begin
          if (!eng_waitrequest_i) begin
            state     <= RUN;
            eng_run_o <= 1'b0;
            first_run <= 1'b1;
          end
        end
        RUN: begin
          // The engine only raises waitrequest one cycle after accept, so skip that cycle.
          if (first_run) begin
            first_run <= 1'b0;
          end else if (!eng_waitrequest_i) begin
            state        <= DONE;
            done_valid_o <= 1'b1;
            done_id_o    <= job_id;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
